tx_lane_scheduler: RTL and testbench

Round-robin scheduler that shares the single 8-bit PHY TX byte path among four lane requesters at the clk_4f rate. It sequences link bring-up by emitting a COM sync burst, then grants one requesting lane per cycle in work-conserving round-robin order. When no lane requests, it inserts IDLE symbols. Its registered byte stream feeds the serializer stage of phy_tx.

---
 rtl/tx_lane_scheduler.sv | 151 +++++++++++++++
 tb/tb_tx_lane_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tx_lane_scheduler.sv
// Four-lane round-robin scheduler onto the single PHY TX byte path.
// Brings the link up with a COM burst, then grants one lane per cycle.
module tx_lane_scheduler #(
  parameter int         SYNC_CYCLES = 4,
  parameter logic [7:0] COM_SYM     = 8'hBC,
  parameter logic [7:0] IDLE_SYM    = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic       grant0,
  output logic       grant1,
  output logic       grant2,
  output logic       grant3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       sync_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] ptr;

  logic [3:0] req;
  logic       hit;
  logic [1:0] win;
  logic [1:0] idx;
  logic       do_grant;
  logic [3:0] gnt;
  logic [7:0] sel_data;

  assign req = {valid_in3, valid_in2, valid_in1, valid_in0};

  // first requester at or after ptr, wrapping modulo 4
  always_comb begin
    hit = 1'b0;
    win = ptr;
    idx = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  assign do_grant = (state == S_ACTIVE) && enable && !reset && hit;
  assign gnt      = do_grant ? (4'b0001 << win) : 4'b0000;

  assign grant0 = gnt[0];
  assign grant1 = gnt[1];
  assign grant2 = gnt[2];
  assign grant3 = gnt[3];

  always_comb begin
    sel_data = data_in0;
    unique case (win)
      2'd0: sel_data = data_in0;
      2'd1: sel_data = data_in1;
      2'd2: sel_data = data_in2;
      2'd3: sel_data = data_in3;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ptr       <= 2'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      lane_out  <= 2'd0;
      sync_busy <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          data_out  <= 8'h00;
          valid_out <= 1'b0;
          lane_out  <= 2'd0;
          sync_busy <= 1'b0;
          cnt       <= 4'd0;
          if (enable) state <= S_SYNC;
        end
        S_SYNC: begin
          if (!enable) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            lane_out  <= 2'd0;
            sync_busy <= 1'b0;
          end else begin
            data_out  <= COM_SYM;
            valid_out <= 1'b0;
            sync_busy <= 1'b1;
            if (cnt == SYNC_LAST) begin
              cnt   <= 4'd0;
              state <= S_ACTIVE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_ACTIVE: begin
          sync_busy <= 1'b0;
          if (!enable) begin
            state     <= S_IDLE;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            lane_out  <= 2'd0;
          end else if (hit) begin
            data_out  <= sel_data;
            valid_out <= 1'b1;
            lane_out  <= win;
            ptr       <= win + 2'd1;
          end else begin
            data_out  <= IDLE_SYM;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= 4'd0;
          data_out  <= 8'h00;
          valid_out <= 1'b0;
          lane_out  <= 2'd0;
          sync_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler with an expected-output queue.
module tb_tx_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       grant0, grant1, grant2, grant3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       sync_busy;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [1:0] l;
    logic       b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  tx_lane_scheduler dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable),
    .data_in0(data_in0), .data_in1(data_in1),
    .data_in2(data_in2), .data_in3(data_in3),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .valid_in2(valid_in2), .valid_in3(valid_in3),
    .grant0(grant0), .grant1(grant1),
    .grant2(grant2), .grant3(grant3),
    .data_out(data_out), .valid_out(valid_out),
    .lane_out(lane_out), .sync_busy(sync_busy)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".data"}, data_out, e.d);
    check({tag, ".valid"}, {7'd0, valid_out}, {7'd0, e.v});
    check({tag, ".lane"}, {6'd0, lane_out}, {6'd0, e.l});
    check({tag, ".busy"}, {7'd0, sync_busy}, {7'd0, e.b});
  endtask

  // drive one cycle, check grants before the edge, outputs after it
  task automatic step(input string tag, input logic en,
                      input logic [3:0] v, input logic [3:0] g,
                      input logic [7:0] d, input logic vo,
                      input logic [1:0] l, input logic b);
    exp_t e;
    enable = en;
    {valid_in3, valid_in2, valid_in1, valid_in0} = v;
    #1;
    check({tag, ".grant"},
          {4'd0, grant3, grant2, grant1, grant0}, {4'd0, g});
    q.push_back('{d: d, v: vo, l: l, b: b});
    @(posedge clk_4f);
    #1;
    e = q.pop_front();
    check_outs(tag, e);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    data_in0 = 8'h10; data_in1 = 8'h11;
    data_in2 = 8'h12; data_in3 = 8'h13;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
    repeat (2) @(posedge clk_4f);
    #1;
    check_outs("rst", '{d: 8'h00, v: 1'b0, l: 2'd0, b: 1'b0});
    reset = 1'b0;

    // bring-up with no requesters
    step("up_idle", 1, 4'b0000, 4'b0000, 8'h00, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++)
      step("up_com", 1, 4'b0000, 4'b0000, 8'hBC, 0, 2'd0, 1);
    step("up_fill0", 1, 4'b0000, 4'b0000, 8'h7C, 0, 2'd0, 0);
    step("up_fill1", 1, 4'b0000, 4'b0000, 8'h7C, 0, 2'd0, 0);

    // all four lanes valid: full rotation, ends with ptr=1
    step("all0", 1, 4'b1111, 4'b0001, 8'h10, 1, 2'd0, 0);
    step("all1", 1, 4'b1111, 4'b0010, 8'h11, 1, 2'd1, 0);
    step("all2", 1, 4'b1111, 4'b0100, 8'h12, 1, 2'd2, 0);
    step("all3", 1, 4'b1111, 4'b1000, 8'h13, 1, 2'd3, 0);
    step("all4", 1, 4'b1111, 4'b0001, 8'h10, 1, 2'd0, 0);

    // lanes 1 and 3 alternate, ends with ptr=0
    step("odd0", 1, 4'b1010, 4'b0010, 8'h11, 1, 2'd1, 0);
    step("odd1", 1, 4'b1010, 4'b1000, 8'h13, 1, 2'd3, 0);
    step("odd2", 1, 4'b1010, 4'b0010, 8'h11, 1, 2'd1, 0);
    step("odd3", 1, 4'b1010, 4'b1000, 8'h13, 1, 2'd3, 0);

    // move ptr to 2, then lanes 0 and 3: 3 wins, then wraps to 0
    step("p2", 1, 4'b0010, 4'b0010, 8'h11, 1, 2'd1, 0);
    step("wrap3", 1, 4'b1001, 4'b1000, 8'h13, 1, 2'd3, 0);
    step("wrap0", 1, 4'b1001, 4'b0001, 8'h10, 1, 2'd0, 0);
    step("nofill", 1, 4'b0000, 4'b0000, 8'h7C, 0, 2'd0, 0);

    // enable drop with lane 2 valid, then a full re-sync (ptr=1)
    step("dis", 0, 4'b0100, 4'b0000, 8'h00, 0, 2'd0, 0);
    step("re_idle", 1, 4'b0100, 4'b0000, 8'h00, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++)
      step("re_com", 1, 4'b0100, 4'b0000, 8'hBC, 0, 2'd0, 1);
    step("re_g2", 1, 4'b0100, 4'b0100, 8'h12, 1, 2'd2, 0);

    // ptr=3; lane 1 carries A5 and leaves ptr=2
    data_in1 = 8'hA5;
    step("a5", 1, 4'b0010, 4'b0010, 8'hA5, 1, 2'd1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("mid_rst", '{d: 8'h00, v: 1'b0, l: 2'd0, b: 1'b0});
    check("mid_rst.grant", {4'd0, grant3, grant2, grant1, grant0}, 8'h00);
    @(posedge clk_4f);
    #1;
    reset = 1'b0;
    data_in1 = 8'h11;

    // ptr cleared: lanes 1 and 2 valid, lane 1 must win first
    step("pr_idle", 1, 4'b0110, 4'b0000, 8'h00, 0, 2'd0, 0);
    for (int i = 0; i < 4; i++)
      step("pr_com", 1, 4'b0110, 4'b0000, 8'hBC, 0, 2'd0, 1);
    step("pr_g1", 1, 4'b0110, 4'b0010, 8'h11, 1, 2'd1, 0);
    step("pr_g2", 1, 4'b0110, 4'b0100, 8'h12, 1, 2'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
